// File: rtl/sdram_tester.sv
// Walks every word address from 0 to LAST_ADDR: writes a pattern, then reads it back.
// Miscompares are counted. A stalled access is cut short by a watchdog.
module sdram_tester #(
  parameter logic [23:0] LAST_ADDR = 24'hFFFFFF,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        mode_i,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  output logic        mem_we_o,
  output logic [24:1] mem_a_o,
  output logic [1:0]  mem_ds_o,
  output logic [15:0] mem_d_o,
  input  logic [15:0] mem_q_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [24:1] err_addr_o,
  output logic [15:0] err_exp_o,
  output logic [15:0] err_got_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_ISSUE = 3'd1;
  localparam logic [2:0] WR_WAIT  = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [24:1] addr_q, addr_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        mode_q, mode_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [24:1] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] wd_q, wd_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic [15:0] errc_q, errc_d;
  logic [24:1] erra_q, erra_d;
  logic [15:0] erre_q, erre_d;
  logic [15:0] errg_q, errg_d;

  logic [15:0] pat;
  logic [15:0] lfsr_nxt;
  logic [15:0] wd_inc;
  logic        acked;
  logic        last;
  logic        is_rd;

  assign pat      = mode_q ? lfsr_q : (addr_q[16:1] ^ {8'h00, addr_q[24:17]});
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign wd_inc   = wd_q + 16'd1;
  assign acked    = (mem_ack_i == req_q);
  assign last     = (addr_q == LAST_ADDR);
  assign is_rd    = (state_q == RD_WAIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    req_d   = req_q;
    we_d    = we_q;
    a_d     = a_q;
    d_d     = d_q;
    wd_d    = wd_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    errc_d  = errc_q;
    erra_d  = erra_q;
    erre_d  = erre_q;
    errg_d  = errg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          // Realign req to ack so a late ack from an aborted run cannot pair with our first request.
          req_d   = mem_ack_i;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          errc_d  = '0;
          erra_d  = '0;
          erre_d  = '0;
          errg_d  = '0;
          addr_d  = '0;
          lfsr_d  = SEED;
          mode_d  = mode_i;
          state_d = WR_ISSUE;
        end
      end
      WR_ISSUE, RD_ISSUE: begin
        a_d     = addr_q;
        d_d     = pat;
        we_d    = (state_q == WR_ISSUE);
        req_d   = ~req_q;
        wd_d    = '0;
        state_d = (state_q == WR_ISSUE) ? WR_WAIT : RD_WAIT;
      end
      WR_WAIT, RD_WAIT: begin
        if (acked) begin
          if (is_rd && (mem_q_i != pat)) begin
            if (errc_q == 16'd0) begin
              erra_d = addr_q;
              erre_d = pat;
              errg_d = mem_q_i;
            end
            if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
          end
          if (last) begin
            addr_d  = '0;
            lfsr_d  = SEED;
            state_d = is_rd ? DONE : RD_ISSUE;
            done_d  = is_rd;
          end else begin
            addr_d  = addr_q + 24'd1;
            lfsr_d  = lfsr_nxt;
            state_d = is_rd ? RD_ISSUE : WR_ISSUE;
          end
        end else begin
          wd_d = wd_inc;
          if (wd_inc == TIMEOUT) begin
            tmo_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lfsr_q  <= SEED;
      mode_q  <= 1'b0;
      req_q   <= mem_ack_i;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      errc_q  <= '0;
      erra_q  <= '0;
      erre_q  <= '0;
      errg_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      req_q   <= req_d;
      we_q    <= we_d;
      a_q     <= a_d;
      d_q     <= d_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      errc_q  <= errc_d;
      erra_q  <= erra_d;
      erre_q  <= erre_d;
      errg_q  <= errg_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_a_o     = a_q;
  assign mem_ds_o    = 2'b11;
  assign mem_d_o     = d_q;
  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = done_q;
  assign pass_o      = done_q && (errc_q == 16'd0) && !tmo_q;
  assign timeout_o   = tmo_q;
  assign err_count_o = errc_q;
  assign err_addr_o  = erra_q;
  assign err_exp_o   = erre_q;
  assign err_got_o   = errg_q;

endmodule

// File: doc/sdram_tester.md
SDRAM_TESTER -- requirements
Module: sdram_tester

Interface
REQ-001 Parameter LAST_ADDR, default 24'hFFFFFF: highest word address tested; the test starts at word address 0.
REQ-002 Parameter SEED, default 16'hACE1: LFSR seed; a value of 0 is illegal.
REQ-003 Parameter TIMEOUT, default 16'd1000: the maximum number of cycles to wait for an ack.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a test run.
REQ-007 mode  in  1  pattern select: 0 = address pattern, 1 = LFSR pattern; sampled on start.
REQ-008 mem_req  out  1  toggle request toward the SDRAM port.
REQ-009 mem_ack  in  1  toggle acknowledge from the SDRAM port.
REQ-010 mem_we  out  1  1 = write, 0 = read.
REQ-011 mem_a  out  24 [24:1]  word address.
REQ-012 mem_ds  out  2  byte enables; always 2'b11.
REQ-013 mem_d  out  16  write data.
REQ-014 mem_q  in  16  read data; valid in the cycle where mem_ack first equals mem_req.
REQ-015 busy  out  1  high while a run is in progress.
REQ-016 done  out  1  high after a run completes; cleared by start or reset.
REQ-017 pass  out  1  done, with no miscompare and no timeout.
REQ-018 timeout  out  1  an ack did not arrive within TIMEOUT cycles.
REQ-019 err_count  out  16  miscompare count; saturates at 16'hFFFF.
REQ-020 err_addr, err_exp, err_got  out  24/16/16  address, expected data and read data of the first miscompare.

Function
REQ-021 States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE.
REQ-022 IDLE/DONE + start: clear done, pass, timeout, err_count and err_*; set addr=0; load LFSR=SEED; go to WR_ISSUE. start is ignored in any other state.
REQ-023 *_ISSUE: drive mem_a=addr, mem_we (1 in WR, 0 in RD), mem_d=pattern(addr); toggle mem_req; go to *_WAIT in the next cycle.
REQ-024 mem_a, mem_we and mem_d shall be stable from the req toggle until mem_ack==mem_req.
REQ-025 A new request shall be issued only when mem_req==mem_ack.
REQ-026 WR_WAIT, on mem_ack==mem_req: if addr==LAST_ADDR, set addr=0, reload LFSR=SEED and go to RD_ISSUE; else increment addr, advance LFSR and go to WR_ISSUE.
REQ-027 RD_WAIT, on mem_ack==mem_req: compare mem_q with pattern(addr) in the same cycle.
REQ-028 On a miscompare: err_count +1 (saturating); if err_count was 0, capture err_addr, err_exp and err_got.
REQ-029 RD_WAIT then advances as in REQ-026; at LAST_ADDR it goes to DONE.
REQ-030 Pattern, mode 0: data = addr[16:1] ^ {8'h00, addr[24:17]}.
REQ-031 Pattern, mode 1: data = current LFSR, Fibonacci, taps x^16+x^14+x^13+x^11+1; shift left, feedback into bit 0; one advance per completed access.
REQ-032 Minimum access period: 1 issue cycle + the responder's latency; there are no idle cycles between accesses.
REQ-033 Watchdog: a 16-bit counter cleared on entry to *_WAIT and incremented each cycle in *_WAIT; on reaching TIMEOUT, set timeout=1 and go to DONE. Any late ack is ignored.
REQ-034 DONE: busy=0, done=1, pass = (err_count==0 && !timeout).
REQ-035 busy=1 in every state except IDLE and DONE.
REQ-036 An ack arriving while in IDLE/DONE causes no state change.

Reset
REQ-037 Reset: state=IDLE, mem_req <= mem_ack (resynchronise, so no spurious request), mem_we=0, mem_a=0, mem_d=0.
REQ-038 Reset also clears busy, done, pass, timeout, err_count, err_*, addr and watchdog.
REQ-039 Reset mid-access abandons the access. The first request after reset shall toggle relative to the resynchronised value.

Verification
REQ-040 Ideal responder model (ack 5 cycles after req, correct memory), LAST_ADDR=15, mode 0, start -> 16 writes, then 16 reads with read data == written data; done=1, pass=1, err_count=0; written data at addr 3 = 16'h0003.
REQ-041 Same setup, mode 1 -> first write data 16'hACE1, second 16'h59C3; pass=1.
REQ-042 Responder forces bit 0 of the read data to 1 at addr 4 (mode 0) -> err_count=1, err_addr=4, err_exp=16'h0004, err_got=16'h0005, pass=0.
REQ-043 Responder never acks the 3rd write, TIMEOUT=20 -> timeout=1, done=1, pass=0, 20 cycles after the req toggle.
REQ-044 Reset asserted in RD_WAIT with mem_ack=1 -> mem_req=1, busy=0; a following start issues a write to addr 0 with mem_req=0.
REQ-045 start pulsed while busy -> no effect on addr or state; the run completes normally.
